// File: rtl/bkg_acq_ctrl_if.sv
// ============================================================================
//  Module   : bkg_acq_ctrl_if
//  Purpose  : Command, sample-stream, RAM-drive and status bundle for the
//             background-accumulation sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bkg_acq_ctrl_if;
    // host commands
    logic        ctrl_enable;
    logic        ctrl_restart;
    // sensor sample stream
    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic [31:0] in_data;
    // background RAM drive
    logic        ram_enable;
    logic [26:0] ram_frame_id;
    logic [7:0]  ram_address;
    logic [31:0] ram_data;
    logic        ram_valid;
    // status
    logic [1:0]  st_state;
    logic [16:0] st_frames;
    logic        st_err_len;

    modport master (
        output ctrl_enable, ctrl_restart, in_valid, in_sof, in_eof, in_data,
        input  ram_enable, ram_frame_id, ram_address, ram_data, ram_valid,
        input  st_state, st_frames, st_err_len
    );

    modport slave (
        input  ctrl_enable, ctrl_restart, in_valid, in_sof, in_eof, in_data,
        output ram_enable, ram_frame_id, ram_address, ram_data, ram_valid,
        output st_state, st_frames, st_err_len
    );
endinterface

`default_nettype wire

// File: rtl/bkg_acq_ctrl.sv
// ============================================================================
//  Module   : bkg_acq_ctrl
//  Purpose  : Sequences the background RAM through IDLE, CLEAR, TOTAL_FRAME
//             accumulation frames (ACCUM) and background output (READY).
//  Options  : BKG_ACQ_CTRL_LEN_CHECK_EN - enables the sticky frame-length
//             error and suppresses counting of mis-sized frames.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bkg_acq_ctrl #(
    parameter int TOTAL_FRAME = 4,
    parameter int CHANNELS    = 256
) (
    input  wire logic       clk_clk,
    input  wire logic       rst_reset,
    bkg_acq_ctrl_if.slave   bus
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_CLEAR     = 2'd1;
    localparam logic [1:0]  c_ACCUM     = 2'd2;
    localparam logic [1:0]  c_READY     = 2'd3;
    localparam logic [8:0]  c_CH        = CHANNELS[8:0];
    localparam logic [8:0]  c_CH_LAST   = c_CH - 9'd1;
    localparam logic [16:0] c_TF        = TOTAL_FRAME[16:0];
    localparam logic [26:0] c_FID_READY = {10'd0, c_TF} + 27'd2;
`ifdef BKG_ACQ_CTRL_LEN_CHECK_EN
    localparam bit          c_LEN_CHECK = 1'b1;
`else
    localparam bit          c_LEN_CHECK = 1'b0;
`endif

    logic [1:0]  r_state, w_state_nxt;
    logic [8:0]  r_clr_addr, w_clr_nxt;
    logic [8:0]  r_idx, w_idx_nxt;
    logic        r_sync, w_sync_nxt;
    // An eof is counted one cycle late so that the eof write still carries the
    // frame id of the frame it belongs to.
    logic        r_pend, w_pend_nxt;
    logic [16:0] r_frames, w_frames_nxt;
    logic        r_err, w_err_nxt;
    logic [26:0] r_fid, w_fid_nxt;
    logic [7:0]  r_addr, w_addr_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_valid, w_valid_nxt;
    logic [8:0]  w_eff_idx;
    logic        w_err_ev;
    logic        w_len_ok;
    logic        w_cnt_done;

    assign w_cnt_done = r_pend && (r_state == c_ACCUM) && ((r_frames + 17'd1) == c_TF);

    // State register.
    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) r_state <= c_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state decode: disable beats restart beats stream progress.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.ctrl_enable) begin
            w_state_nxt = c_IDLE;
        end else if (bus.ctrl_restart) begin
            w_state_nxt = c_CLEAR;
        end else begin
            case (r_state)
                c_CLEAR: if (r_clr_addr == c_CH) w_state_nxt = c_ACCUM;
                c_ACCUM: if (w_cnt_done)         w_state_nxt = c_READY;
                default: ;
            endcase
        end
    end

    // Next values for the datapath and the registered RAM/status outputs.
    always_comb begin
        w_clr_nxt    = r_clr_addr;
        w_idx_nxt    = r_idx;
        w_sync_nxt   = r_sync;
        w_pend_nxt   = r_pend;
        w_frames_nxt = r_frames;
        w_err_nxt    = r_err;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_eff_idx    = r_idx;
        w_err_ev     = 1'b0;
        w_len_ok     = 1'b0;
        w_fid_nxt    = 27'd0;
        if (!bus.ctrl_enable) begin
            w_clr_nxt  = 9'd0;
            w_idx_nxt  = 9'd0;
            w_sync_nxt = 1'b0;
            w_pend_nxt = 1'b0;
            w_addr_nxt = 8'd0;
            w_data_nxt = 32'd0;
        end else if (bus.ctrl_restart) begin
            // first clear write (address 0) goes out together with the state
            w_clr_nxt    = 9'd1;
            w_idx_nxt    = 9'd0;
            w_sync_nxt   = 1'b0;
            w_pend_nxt   = 1'b0;
            w_frames_nxt = 17'd0;
            w_err_nxt    = 1'b0;
            w_addr_nxt   = 8'd0;
            w_data_nxt   = 32'd0;
            w_valid_nxt  = 1'b1;
        end else begin
            case (r_state)
                c_CLEAR: begin
                    if (r_clr_addr == c_CH) begin
                        w_clr_nxt    = 9'd0;
                        w_idx_nxt    = 9'd0;
                        w_sync_nxt   = 1'b0;
                        w_pend_nxt   = 1'b0;
                        w_frames_nxt = 17'd0;
                    end else begin
                        w_addr_nxt  = r_clr_addr[7:0];
                        w_data_nxt  = 32'd0;
                        w_valid_nxt = 1'b1;
                        w_clr_nxt   = r_clr_addr + 9'd1;
                    end
                end
                c_ACCUM, c_READY: begin
                    if (r_pend) begin
                        w_frames_nxt = r_frames + 17'd1;
                        w_pend_nxt   = 1'b0;
                    end
                    if (bus.in_valid && (r_sync || bus.in_sof)) begin
                        if (bus.in_sof) begin
                            w_eff_idx  = 9'd0;
                            w_sync_nxt = 1'b1;
                            if (r_sync && (r_idx != 9'd0)) w_err_ev = 1'b1;
                        end
                        if (w_eff_idx < c_CH) begin
                            w_addr_nxt  = w_eff_idx[7:0];
                            w_data_nxt  = bus.in_data;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_err_ev = 1'b1;
                        end
                        if (bus.in_eof) begin
                            w_len_ok  = (w_eff_idx == c_CH_LAST);
                            if (!w_len_ok) w_err_ev = 1'b1;
                            w_idx_nxt = 9'd0;
                            if ((r_state == c_ACCUM) && !w_cnt_done && (w_len_ok || !c_LEN_CHECK))
                                w_pend_nxt = 1'b1;
                        end else if (w_eff_idx < c_CH) begin
                            w_idx_nxt = w_eff_idx + 9'd1;
                        end else begin
                            w_idx_nxt = c_CH;
                        end
                    end
                end
                default: ;
            endcase
            w_err_nxt = r_err | (w_err_ev & c_LEN_CHECK);
        end
        // frame id follows the state that becomes visible with this write
        case (w_state_nxt)
            c_IDLE:  w_fid_nxt = 27'd0;
            c_CLEAR: w_fid_nxt = 27'd1;
            c_ACCUM: w_fid_nxt = {10'd0, w_frames_nxt} + 27'd2;
            default: w_fid_nxt = c_FID_READY;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            r_clr_addr <= 9'd0;
            r_idx      <= 9'd0;
            r_sync     <= 1'b0;
            r_pend     <= 1'b0;
            r_frames   <= 17'd0;
            r_err      <= 1'b0;
            r_fid      <= 27'd0;
            r_addr     <= 8'd0;
            r_data     <= 32'd0;
            r_valid    <= 1'b0;
        end else begin
            r_clr_addr <= w_clr_nxt;
            r_idx      <= w_idx_nxt;
            r_sync     <= w_sync_nxt;
            r_pend     <= w_pend_nxt;
            r_frames   <= w_frames_nxt;
            r_err      <= w_err_nxt;
            r_fid      <= w_fid_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign bus.ram_enable   = (r_state != c_IDLE);
    assign bus.ram_frame_id = r_fid;
    assign bus.ram_address  = r_addr;
    assign bus.ram_data     = r_data;
    assign bus.ram_valid    = r_valid;
    assign bus.st_state     = r_state;
    assign bus.st_frames    = r_frames;
    assign bus.st_err_len   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bkg_acq_ctrl.sv
// ============================================================================
//  Module   : tb_bkg_acq_ctrl
//  Purpose  : Directed bench for bkg_acq_ctrl with a cycle model of the
//             sequencer's rules and literal checkpoints.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bkg_acq_ctrl;

    localparam int TF = 4;
    localparam int CH = 256;
`ifdef BKG_ACQ_CTRL_LEN_CHECK_EN
    localparam bit LEN = 1'b1;
`else
    localparam bit LEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bkg_acq_ctrl_if bus();

    bkg_acq_ctrl #(.TOTAL_FRAME(TF), .CHANNELS(CH)) dut (
        .clk_clk   (clk),
        .rst_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_state = 0, m_frames = 0, m_idx = 0, m_clr = 0;
    bit   m_sync = 0, m_err = 0, m_pend = 0, ok;
    bit   e_valid = 0;
    int   e_addr = 0;
    logic [31:0] e_data = 0;

    function automatic int exp_fid(input int st, input int fr);
        case (st)
            0: return 0;
            1: return 1;
            2: return fr + 2;
            default: return TF + 2;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_frames = 0; m_idx = 0; m_clr = 0;
            m_sync = 0; m_err = 0; m_pend = 0;
            e_valid = 0; e_addr = 0; e_data = 0;
        end else begin
            e_valid = 0;
            if (!bus.ctrl_enable) begin
                m_state = 0; m_clr = 0; m_sync = 0; m_idx = 0; m_pend = 0;
                e_addr = 0; e_data = 0;
            end else if (bus.ctrl_restart) begin
                m_state = 1; m_clr = 1; m_frames = 0; m_err = 0;
                m_sync = 0; m_idx = 0; m_pend = 0;
                e_valid = 1; e_addr = 0; e_data = 0;
            end else if (m_state == 1) begin
                if (m_clr == CH) begin
                    m_state = 2; m_frames = 0; m_sync = 0; m_idx = 0; m_clr = 0;
                end else begin
                    e_valid = 1; e_addr = m_clr; e_data = 0; m_clr++;
                end
            end else if (m_state >= 2) begin
                if (m_pend) begin
                    m_pend = 0; m_frames++;
                    if (m_frames == TF) m_state = 3;
                end
                if (bus.in_valid && (bus.in_sof || m_sync)) begin
                    if (bus.in_sof) begin
                        if (m_sync && m_idx != 0) m_err |= LEN;
                        m_sync = 1; m_idx = 0;
                    end
                    if (m_idx < CH) begin
                        e_valid = 1; e_addr = m_idx; e_data = bus.in_data;
                    end else begin
                        m_err |= LEN;
                    end
                    if (bus.in_eof) begin
                        ok = (m_idx == CH - 1);
                        if (!ok) m_err |= LEN;
                        if (m_state == 2 && (ok || !LEN)) m_pend = 1;
                        m_idx = 0;
                    end else begin
                        m_idx = (m_idx + 1 > CH) ? CH : m_idx + 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("st_state",     32'(bus.st_state),     32'(m_state));
            chk("ram_frame_id", 32'(bus.ram_frame_id), 32'(exp_fid(m_state, m_frames)));
            chk("ram_enable",   32'(bus.ram_enable),   32'(m_state != 0));
            chk("ram_valid",    32'(bus.ram_valid),    32'(e_valid));
            chk("st_frames",    32'(bus.st_frames),    32'(m_frames));
            chk("st_err_len",   32'(bus.st_err_len),   32'(m_err));
            if (e_valid) begin
                chk("ram_address", 32'(bus.ram_address), 32'(e_addr));
                chk("ram_data",    bus.ram_data,          e_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input int n, input bit sof, input bit eof,
                              input logic [31:0] d0, input bit inc,
                              input int gap, input bit chk_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_first && i == 1) begin
                chk("first_sof_addr",  32'(bus.ram_address), 32'd0);
                chk("first_sof_valid", 32'(bus.ram_valid),   32'd1);
            end
            bus.in_valid = 1'b1;
            bus.in_sof   = sof && (i == 0);
            bus.in_eof   = eof && (i == n - 1);
            bus.in_data  = inc ? d0 + 32'(i) : d0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        bus.ctrl_restart = 1'b1;
        @(negedge clk);
        bus.ctrl_restart = 1'b0;
    endtask

    task automatic check_clear_start(input string tag);
        chk({tag, "_state"},  32'(bus.st_state),     32'd1);
        chk({tag, "_addr"},   32'(bus.ram_address),  32'd0);
        chk({tag, "_valid"},  32'(bus.ram_valid),    32'd1);
        chk({tag, "_fid"},    32'(bus.ram_frame_id), 32'd1);
        chk({tag, "_frames"}, 32'(bus.st_frames),    32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.ctrl_enable = 1'b0; bus.ctrl_restart = 1'b0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.in_data = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_state",  32'(bus.st_state),     32'd0);
        chk("rst_fid",    32'(bus.ram_frame_id), 32'd0);
        chk("rst_enable", 32'(bus.ram_enable),   32'd0);
        chk("rst_valid",  32'(bus.ram_valid),    32'd0);
        chk("rst_addr",   32'(bus.ram_address),  32'd0);
        chk("rst_data",   bus.ram_data,          32'd0);
        chk("rst_frames", 32'(bus.st_frames),    32'd0);
        chk("rst_err",    32'(bus.st_err_len),   32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        bus.ctrl_enable = 1'b1;

        // clear walk
        do_restart();
        check_clear_start("clr1");
        chk("clr1_enable", 32'(bus.ram_enable), 32'd1);
        repeat (255) @(negedge clk);
        chk("clr_last_addr",  32'(bus.ram_address), 32'd255);
        chk("clr_last_valid", 32'(bus.ram_valid),   32'd1);
        @(negedge clk);
        chk("accum_state", 32'(bus.st_state),     32'd2);
        chk("accum_fid",   32'(bus.ram_frame_id), 32'd2);

        // samples before first sof are dropped
        send_frame(5, 1'b0, 1'b1, 32'hDEAD0000, 1'b1, 0, 1'b0);
        chk("nosync_valid", 32'(bus.ram_valid), 32'd0);

        // four clean frames
        for (int f = 0; f < 4; f++) begin
            send_frame(CH, 1'b1, 1'b1, 32'h00010002, 1'b0, 0, f == 0);
            chk("eof_fid",   32'(bus.ram_frame_id), 32'(2 + f));
            chk("eof_valid", 32'(bus.ram_valid),    32'd1);
            chk("eof_data",  bus.ram_data,          32'h00010002);
            @(negedge clk);
            if (f < 3) chk("next_fid", 32'(bus.ram_frame_id), 32'(3 + f));
        end
        chk("ready_state",  32'(bus.st_state),     32'd3);
        chk("ready_fid",    32'(bus.ram_frame_id), 32'd6);
        chk("ready_frames", 32'(bus.st_frames),    32'd4);

        // READY pass-through, then reset mid-frame
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_sof = (i == 0); bus.in_eof = 1'b0;
            bus.in_data = 32'h00A00000 + 32'(i);
        end
        @(negedge clk);
        chk("ready_addr", 32'(bus.ram_address), 32'd99);
        chk("ready_data", bus.ram_data,         32'h00A00063);
        #2 rst = 1'b1;
        #1;
        chk("arst_state",  32'(bus.st_state),     32'd0);
        chk("arst_fid",    32'(bus.ram_frame_id), 32'd0);
        chk("arst_enable", 32'(bus.ram_enable),   32'd0);
        chk("arst_valid",  32'(bus.ram_valid),    32'd0);
        chk("arst_addr",   32'(bus.ram_address),  32'd0);
        chk("arst_data",   bus.ram_data,          32'd0);
        chk("arst_frames", 32'(bus.st_frames),    32'd0);
        chk("arst_err",    32'(bus.st_err_len),   32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_restart();
        check_clear_start("clr2");
        repeat (256) @(negedge clk);
        chk("accum2_state", 32'(bus.st_state), 32'd2);

        // short frame
        send_frame(200, 1'b1, 1'b1, 32'h00200000, 1'b1, 0, 1'b0);
        @(negedge clk);
        chk("short_frames", 32'(bus.st_frames),  LEN ? 32'd0 : 32'd1);
        chk("short_err",    32'(bus.st_err_len), LEN ? 32'd1 : 32'd0);

        // full frame, then restart during the next one
        send_frame(CH, 1'b1, 1'b1, 32'h00300000, 1'b1, 0, 1'b0);
        @(negedge clk);
        chk("full_frames", 32'(bus.st_frames), LEN ? 32'd1 : 32'd2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_sof = (i == 0); bus.in_eof = 1'b0;
            bus.in_data = 32'h00400000 + 32'(i);
        end
        @(negedge clk);
        bus.ctrl_restart = 1'b1;
        bus.in_data = 32'h00400032;
        @(negedge clk);
        bus.ctrl_restart = 1'b0; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        check_clear_start("clr3");
        chk("clr3_err", 32'(bus.st_err_len), 32'd0);
        repeat (256) @(negedge clk);
        chk("accum3_state", 32'(bus.st_state), 32'd2);

        // overflow, mid-frame sof, one-sample frame, gapped frame
        send_frame(300, 1'b1, 1'b1, 32'h00500000, 1'b1, 0, 1'b0);
        chk("ovf_valid", 32'(bus.ram_valid), 32'd0);
        send_frame(20, 1'b1, 1'b0, 32'h00600000, 1'b1, 0, 1'b0);
        send_frame(CH, 1'b1, 1'b1, 32'h00700000, 1'b1, 0, 1'b0);
        send_frame(1, 1'b1, 1'b1, 32'h00800000, 1'b0, 0, 1'b0);
        chk("one_valid", 32'(bus.ram_valid),   32'd1);
        chk("one_addr",  32'(bus.ram_address), 32'd0);
        @(negedge clk);
        chk("edge_frames", 32'(bus.st_frames),  LEN ? 32'd1 : 32'd3);
        chk("edge_err",    32'(bus.st_err_len), LEN ? 32'd1 : 32'd0);
        send_frame(CH, 1'b1, 1'b1, 32'h00900000, 1'b1, 1, 1'b0);
        @(negedge clk);
        chk("gap_state", 32'(bus.st_state), LEN ? 32'd2 : 32'd3);

        // disable beats restart
        @(negedge clk);
        bus.ctrl_enable = 1'b0; bus.ctrl_restart = 1'b1;
        @(negedge clk);
        bus.ctrl_restart = 1'b0;
        chk("dis_state",  32'(bus.st_state),     32'd0);
        chk("dis_fid",    32'(bus.ram_frame_id), 32'd0);
        chk("dis_enable", 32'(bus.ram_enable),   32'd0);
        @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
